// File: rtl/axi_mem.sv
// axi_mem: AXI4 responder over a 32-bit word memory, with independent read and write FSMs.
// Optional build macro AXI_MEM_BACKPRESSURE_EN adds LFSR-driven ready gating and response delays.
package axi_mem_pkg;
  localparam int unsigned ID_W = 4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic            awvalid;
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [1:0]      awburst;
    logic            wvalid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            bready;
    logic            arvalid;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [1:0]      arburst;
    logic            rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic            bvalid;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            arready;
    logic            rvalid;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
  } s_axi_miso_t;
endpackage

module axi_mem
  import axi_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t axi_mosi_i,
  output s_axi_miso_t axi_miso_o
);
  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [33:0] SPAN  = 34'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_BURST} r_state_e;

  // Addresses carry a 33rd bit so an INCR burst running past 4 GiB never wraps back into range.
  function automatic logic in_range(input logic [32:0] a);
    logic [33:0] off;
    off = {1'b0, a} - {2'b00, BASE_ADDR};
    return !off[33] && (off < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [32:0] a);
    logic [33:0] off;
    off = {1'b0, a} - {2'b00, BASE_ADDR};
    return IDX_W'(off >> 2);
  endfunction

  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

  function automatic logic [32:0] next_addr(input logic [32:0] a, input logic [1:0] b);
    return (b == BURST_INCR) ? a + 33'd4 : a;
  endfunction

  logic [31:0] mem_q [MEM_WORDS];

  w_state_e        w_state_q, w_state_d;
  logic [32:0]     w_addr_q, w_addr_d;
  logic [1:0]      w_burst_q, w_burst_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d, bdly_q, bdly_d;
  logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;

  r_state_e        r_state_q, r_state_d;
  logic [32:0]     r_addr_q, r_addr_d;
  logic [1:0]      r_burst_q, r_burst_d, rresp_q, rresp_d, rdly_q, rdly_d;
  logic [7:0]      r_cnt_q, r_cnt_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d;

  logic             aw_hs_c, w_hs_c, ar_hs_c, r_hs_c, mem_we_c, load_c;
  logic [IDX_W-1:0] mem_widx_c;
  logic [32:0]      beat_addr_c;
  logic [1:0]       beat_burst_c;
  logic             aw_gate_c, w_gate_c, ar_gate_c;
  logic [1:0]       bdly_seed_c, rdly_seed_c;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
  assign aw_gate_c   = lfsr_q[0];
  assign w_gate_c    = lfsr_q[3];
  assign ar_gate_c   = lfsr_q[7];
  assign bdly_seed_c = lfsr_q[5:4];
  assign rdly_seed_c = lfsr_q[9:8];
`else
  assign aw_gate_c   = 1'b1;
  assign w_gate_c    = 1'b1;
  assign ar_gate_c   = 1'b1;
  assign bdly_seed_c = 2'd0;
  assign rdly_seed_c = 2'd0;
`endif

  // Write FSM: latch AW, store enabled bytes per beat, hold B until accepted.
  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_burst_d  = w_burst_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    bdly_d     = bdly_q;
    mem_we_c   = 1'b0;
    mem_widx_c = word_idx(w_addr_q);
    aw_hs_c    = axi_mosi_i.awvalid && awready_q;
    w_hs_c     = axi_mosi_i.wvalid && wready_q;
    case (w_state_q)
      W_IDLE: if (aw_hs_c) begin
        w_addr_d  = {1'b0, axi_mosi_i.awaddr};
        w_burst_d = axi_mosi_i.awburst;
        bid_d     = axi_mosi_i.awid;
        bresp_d   = burst_ok(axi_mosi_i.awburst) ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_hs_c) begin
        if (burst_ok(w_burst_q)) begin
          if (in_range(w_addr_q)) mem_we_c = 1'b1;
          else                    bresp_d  = RESP_DECERR;
        end
        w_addr_d = next_addr(w_addr_q, w_burst_q);
        if (axi_mosi_i.wlast) begin
          w_state_d = W_RESP;
          bdly_d    = bdly_seed_c;
        end
      end
      W_RESP: begin
        if (bdly_q != 2'd0) bdly_d = bdly_q - 2'd1;
        if (bvalid_q && axi_mosi_i.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && aw_gate_c;
    wready_d  = (w_state_d == W_DATA) && w_gate_c;
    bvalid_d  = (w_state_d == W_RESP) && (bvalid_q || (bdly_d == 2'd0));
  end

  // Read FSM: each accepted beat fetches the next one into the output registers.
  always_comb begin
    r_state_d    = r_state_q;
    r_addr_d     = r_addr_q;
    r_burst_d    = r_burst_q;
    r_cnt_d      = r_cnt_q;
    rid_d        = rid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    rlast_d      = rlast_q;
    rdly_d       = rdly_q;
    load_c       = 1'b0;
    beat_addr_c  = r_addr_q;
    beat_burst_c = r_burst_q;
    ar_hs_c      = axi_mosi_i.arvalid && arready_q;
    r_hs_c       = rvalid_q && axi_mosi_i.rready;
    case (r_state_q)
      R_IDLE: if (ar_hs_c) begin
        load_c       = 1'b1;
        beat_addr_c  = {1'b0, axi_mosi_i.araddr};
        beat_burst_c = axi_mosi_i.arburst;
        rid_d        = axi_mosi_i.arid;
        r_cnt_d      = axi_mosi_i.arlen;
        rlast_d      = (axi_mosi_i.arlen == 8'd0);
        r_state_d    = R_BURST;
      end
      R_BURST: begin
        if (rdly_q != 2'd0) rdly_d = rdly_q - 2'd1;
        if (r_hs_c) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rlast_d   = 1'b0;
          end else begin
            load_c      = 1'b1;
            beat_addr_c = next_addr(r_addr_q, r_burst_q);
            r_cnt_d     = r_cnt_q - 8'd1;
            rlast_d     = (r_cnt_q == 8'd1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (load_c) begin
      r_addr_d  = beat_addr_c;
      r_burst_d = beat_burst_c;
      rdly_d    = rdly_seed_c;
      if (!burst_ok(beat_burst_c)) begin
        rresp_d = RESP_SLVERR;
        rdata_d = 32'h0;
      end else if (!in_range(beat_addr_c)) begin
        rresp_d = RESP_DECERR;
        rdata_d = 32'h0;
      end else begin
        rresp_d = RESP_OKAY;
        rdata_d = mem_q[word_idx(beat_addr_c)];
      end
    end
    arready_d = (r_state_d == R_IDLE) && ar_gate_c;
    rvalid_d  = (r_state_d == R_BURST) && ((rvalid_q && !r_hs_c) || (rdly_d == 2'd0));
  end

  // Storage has no reset; reads sample the pre-edge contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (axi_mosi_i.wstrb[b]) mem_q[mem_widx_c][8*b +: 8] <= axi_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= 33'h0;
      w_burst_q <= 2'b00;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      bdly_q    <= 2'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_addr_q  <= 33'h0;
      r_burst_q <= 2'b00;
      r_cnt_q   <= 8'd0;
      rid_q     <= '0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'h0;
      rlast_q   <= 1'b0;
      rdly_q    <= 2'd0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_burst_q <= w_burst_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bdly_q    <= bdly_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rdly_q    <= rdly_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign axi_miso_o.awready = awready_q;
  assign axi_miso_o.wready  = wready_q;
  assign axi_miso_o.bvalid  = bvalid_q;
  assign axi_miso_o.bid     = bid_q;
  assign axi_miso_o.bresp   = bresp_q;
  assign axi_miso_o.arready = arready_q;
  assign axi_miso_o.rvalid  = rvalid_q;
  assign axi_miso_o.rid     = rid_q;
  assign axi_miso_o.rdata   = rdata_q;
  assign axi_miso_o.rresp   = rresp_q;
  assign axi_miso_o.rlast   = rlast_q;
endmodule

// File: tb/tb_axi_mem.sv
// tb_axi_mem: directed self-checking bench for axi_mem (default build, BASE_ADDR 0, 1024 words).
module tb_axi_mem;
  import axi_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;

  int tests  = 0;
  int errors = 0;

  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];
  int          rd_n;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 clk = ~clk;

  axi_mem #(.MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .axi_mosi_i(mosi),
    .axi_miso_o(miso)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge; inputs change only there.
  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
    int n;
    mosi.awvalid = 1'b1;
    mosi.awid    = id;
    mosi.awaddr  = addr;
    mosi.awlen   = 8'(len);
    mosi.awburst = burst;
    n = 0;
    while (!miso.awready && n < 100) begin @(negedge clk); n++; end
    check("aw_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    mosi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      mosi.wvalid = 1'b1;
      mosi.wdata  = wd[i];
      mosi.wstrb  = ws[i];
      mosi.wlast  = (i == len);
      n = 0;
      while (!miso.wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("w_wait", 32'(n), 32'd0);
      @(negedge clk);
    end
    mosi.wvalid = 1'b0;
    mosi.wlast  = 1'b0;
    mosi.bready = 1'b1;
    n = 0;
    while (!miso.bvalid && n < 100) begin @(negedge clk); n++; end
    check("b_wait", 32'(n < 100), 32'd1);
    b_resp = miso.bresp;
    b_id   = miso.bid;
    @(negedge clk);
    mosi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input bit toggle, input int max_beats);
    int n, cyc;
    bit done, stalled;
    logic [31:0] hold_data;
    logic        hold_last;
    mosi.arvalid = 1'b1;
    mosi.arid    = id;
    mosi.araddr  = addr;
    mosi.arlen   = 8'(len);
    mosi.arburst = burst;
    n = 0;
    while (!miso.arready && n < 100) begin @(negedge clk); n++; end
    check("ar_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    mosi.arvalid = 1'b0;
    check("rvalid_latency", 32'(miso.rvalid), 32'd1);
    rd_n = 0; cyc = 0; done = 1'b0; stalled = 1'b0;
    hold_data = '0; hold_last = 1'b0;
    while (!done && rd_n < max_beats && cyc < 2000) begin
      mosi.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (miso.rvalid) begin
        if (stalled) begin
          check("stall_rdata", miso.rdata, hold_data);
          check("stall_rlast", 32'(miso.rlast), 32'(hold_last));
        end
        if (mosi.rready) begin
          rd_data[rd_n] = miso.rdata;
          rd_resp[rd_n] = miso.rresp;
          rd_last[rd_n] = miso.rlast;
          rd_id[rd_n]   = miso.rid;
          rd_n++;
          stalled = 1'b0;
          done    = miso.rlast;
        end else begin
          stalled   = 1'b1;
          hold_data = miso.rdata;
          hold_last = miso.rlast;
        end
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) check("r_wait", 32'(cyc), 32'd0);
    mosi.rready = 1'b0;
  endtask

  initial begin
    mosi = '0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(miso.awready), 32'd0);
    check("rst_arready", 32'(miso.arready), 32'd0);
    check("rst_wready", 32'(miso.wready), 32'd0);
    check("rst_bvalid", 32'(miso.bvalid), 32'd0);
    check("rst_rvalid", 32'(miso.rvalid), 32'd0);
    check("rst_rlast", 32'(miso.rlast), 32'd0);
    check("rst_resp_fields", 32'({miso.bid, miso.bresp, miso.rid, miso.rresp}), 32'd0);
    check("rst_rdata", miso.rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", 32'(miso.awready), 32'd1);
    check("post_rst_arready", 32'(miso.arready), 32'd1);

    // Single write then read at 0x10
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    axi_write(4'h3, 32'h10, 0, BURST_INCR);
    check("single_bresp", 32'(b_resp), 32'(RESP_OKAY));
    check("single_bid", 32'(b_id), 32'h3);
    axi_read(4'h5, 32'h10, 0, BURST_INCR, 1'b0, 256);
    check("single_beats", 32'(rd_n), 32'd1);
    check("single_rdata", rd_data[0], 32'hDEADBEEF);
    check("single_rresp", 32'(rd_resp[0]), 32'(RESP_OKAY));
    check("single_rlast", 32'(rd_last[0]), 32'd1);
    check("single_rid", 32'(rd_id[0]), 32'h5);

    // INCR burst with a partial strobe over 0xFFFFFFFF
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
    axi_write(4'h1, 32'h100, 3, BURST_INCR);
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    ws[1] = 4'h3;
    axi_write(4'h2, 32'h100, 3, BURST_INCR);
    check("incr_bresp", 32'(b_resp), 32'(RESP_OKAY));
    axi_read(4'h2, 32'h100, 3, BURST_INCR, 1'b0, 256);
    check("incr_beats", 32'(rd_n), 32'd4);
    check("incr_d0", rd_data[0], 32'h1);
    check("incr_d1", rd_data[1], 32'hFFFF0002);
    check("incr_d2", rd_data[2], 32'h3);
    check("incr_d3", rd_data[3], 32'h4);
    for (int i = 0; i < 4; i++) check("incr_rlast", 32'(rd_last[i]), 32'(i == 3));

    // arlen=7 read with rready toggling
    for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    axi_write(4'h4, 32'h200, 7, BURST_INCR);
    axi_read(4'h9, 32'h200, 7, BURST_INCR, 1'b1, 256);
    check("stall_beats", 32'(rd_n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("stall_data", rd_data[i], 32'hA0 + 32'(i));
      check("stall_rid", 32'(rd_id[i]), 32'h9);
      check("stall_last", 32'(rd_last[i]), 32'(i == 7));
    end

    // Burst crossing the top of memory
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    axi_write(4'h0, 32'h0, 0, BURST_INCR);
    wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(4'h7, 32'hFFC, 1, BURST_INCR);
    check("top_bresp", 32'(b_resp), 32'(RESP_DECERR));
    axi_read(4'h7, 32'hFFC, 1, BURST_INCR, 1'b0, 256);
    check("top_beats", 32'(rd_n), 32'd2);
    check("top_d0", rd_data[0], 32'h55);
    check("top_r0", 32'(rd_resp[0]), 32'(RESP_OKAY));
    check("top_r1", 32'(rd_resp[1]), 32'(RESP_DECERR));
    check("top_d1", rd_data[1], 32'h0);
    axi_read(4'h0, 32'h0, 0, BURST_INCR, 1'b0, 256);
    check("word0_kept", rd_data[0], 32'h12345678);

    // Same-edge write and read of 0x20: read-first
    wd[0] = 32'h11; ws[0] = 4'hF;
    axi_write(4'h0, 32'h20, 0, BURST_INCR);
    mosi.awvalid = 1'b1; mosi.awid = 4'hA; mosi.awaddr = 32'h20; mosi.awlen = 8'd0;
    mosi.awburst = BURST_INCR;
    @(negedge clk);
    mosi.awvalid = 1'b0;
    check("rf_wready", 32'(miso.wready), 32'd1);
    mosi.wvalid = 1'b1; mosi.wdata = 32'h22; mosi.wstrb = 4'hF; mosi.wlast = 1'b1;
    mosi.arvalid = 1'b1; mosi.arid = 4'hB; mosi.araddr = 32'h20; mosi.arlen = 8'd0;
    mosi.arburst = BURST_INCR;
    @(negedge clk);
    mosi.wvalid = 1'b0; mosi.wlast = 1'b0; mosi.arvalid = 1'b0;
    check("rf_rvalid", 32'(miso.rvalid), 32'd1);
    check("rf_old_data", miso.rdata, 32'h11);
    check("rf_bvalid", 32'(miso.bvalid), 32'd1);
    check("rf_bid", 32'(miso.bid), 32'hA);
    mosi.rready = 1'b1; mosi.bready = 1'b1;
    @(negedge clk);
    mosi.rready = 1'b0; mosi.bready = 1'b0;
    check("rf_rvalid_drop", 32'(miso.rvalid), 32'd0);
    check("rf_bvalid_drop", 32'(miso.bvalid), 32'd0);
    axi_read(4'h1, 32'h20, 0, BURST_INCR, 1'b0, 256);
    check("rf_new_data", rd_data[0], 32'h22);

    // FIXED keeps the address; WRAP is rejected with SLVERR and discarded
    wd[0] = 32'h7; wd[1] = 32'h8; wd[2] = 32'h9; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
    axi_write(4'h2, 32'h400, 2, BURST_FIXED);
    check("fixed_bresp", 32'(b_resp), 32'(RESP_OKAY));
    axi_read(4'h2, 32'h400, 1, BURST_INCR, 1'b0, 256);
    check("fixed_last_wins", rd_data[0], 32'h9);
    wd[0] = 32'hCAFE0000; ws[0] = 4'hF;
    axi_write(4'h3, 32'h300, 0, BURST_INCR);
    wd[0] = 32'hBAD; wd[1] = 32'hBAD;
    axi_write(4'h3, 32'h300, 1, BURST_WRAP);
    check("wrap_bresp", 32'(b_resp), 32'(RESP_SLVERR));
    axi_read(4'h3, 32'h300, 0, BURST_INCR, 1'b0, 256);
    check("wrap_discarded", rd_data[0], 32'hCAFE0000);
    axi_read(4'h3, 32'h300, 1, BURST_WRAP, 1'b0, 256);
    check("wrap_rd_beats", 32'(rd_n), 32'd2);
    check("wrap_rd_resp", 32'(rd_resp[1]), 32'(RESP_SLVERR));
    check("wrap_rd_data", rd_data[0], 32'h0);

    // Reset during beat 3 of an 8-beat read
    axi_read(4'h6, 32'h200, 7, BURST_INCR, 1'b0, 3);
    check("rstmid_beats", 32'(rd_n), 32'd3);
    check("rstmid_d2", rd_data[2], 32'hA2);
    check("rstmid_valid_b3", 32'(miso.rvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rvalid", 32'(miso.rvalid), 32'd0);
    check("rstmid_arready", 32'(miso.arready), 32'd0);
    check("rstmid_rid", 32'(miso.rid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_arready_after", 32'(miso.arready), 32'd1);
    check("rstmid_no_resp", 32'(miso.rvalid), 32'd0);
    axi_read(4'h6, 32'h200, 0, BURST_INCR, 1'b0, 256);
    check("rstmid_retained", rd_data[0], 32'hA0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/axi_mem.md
AXI_MEM -- requirements
Module: axi_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, 1024, depth of 32-bit storage (power of two).
REQ-002 SHALL have parameter BASE_ADDR, 32'h0, byte address of word 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port axi_mosi_i  input  s_axi_mosi_t  AXI4 request channels (AW, W, AR, B/R ready) from the core.
REQ-006 SHALL have port axi_miso_o  output  s_axi_miso_t  AXI4 response channels (AW/W/AR ready, B, R) to the core.

Function
REQ-007 SHALL act as the AXI4 responder to the core's fetch and load-store masters, with a 32-bit data path and beat size 4 bytes.
REQ-008 SHALL run the write path and read path as independent FSMs; both may be active in the same cycle.
REQ-009 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP: W_IDLE has awready=1; AW handshake latches awid/awaddr/awlen/awburst and moves to W_DATA.
REQ-010 In W_DATA, wready SHALL be 1; each W handshake writes the bytes enabled by wstrb, then advances the address per burst type.
REQ-011 W handshake with wlast=1 SHALL move to W_RESP; bvalid=1 from the next cycle with bid=latched awid, held until bready; then back to W_IDLE.
REQ-012 Read FSM SHALL have states R_IDLE, R_BURST: R_IDLE has arready=1; AR handshake in cycle N latches the request, and the first rvalid SHALL appear in cycle N+1.
REQ-013 In R_BURST, rdata/rid/rresp/rlast SHALL stay stable while rvalid=1 and rready=0; each R handshake advances to the next beat with no bubble.
REQ-014 rlast SHALL be 1 exactly on beat arlen+1; its handshake returns to R_IDLE.
REQ-015 INCR bursts SHALL add 4 per beat; FIXED bursts SHALL keep the address; WRAP or reserved burst types SHALL be completed beat-for-beat with SLVERR, writes discarded, rdata=0.
REQ-016 Word index SHALL be (addr-BASE_ADDR)>>2; any beat whose address falls outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) SHALL return DECERR (rresp per beat, bresp sticky over the burst) and not modify storage.
REQ-017 Bursts crossing the top of the range SHALL error only the out-of-range beats; the index SHALL never wrap into low memory.
REQ-018 Same-cycle write and read to one word SHALL return the old data (read-first).
REQ-019 Valid bursts SHALL return OKAY; awlen/arlen up to 255 SHALL be supported.

Reset
REQ-020 While rst=1, both FSMs SHALL go to idle state; bvalid, rvalid, rlast, wready SHALL be 0; awready and arready SHALL be 0 during reset and 1 in the first cycle after.
REQ-021 Reset asserted mid-burst SHALL abandon the burst with no further response; storage contents SHALL be retained.
REQ-022 All response fields (bid, bresp, rid, rresp, rdata) SHALL reset to 0.

Configuration
REQ-023 Macro AXI_MEM_BACKPRESSURE_EN SHALL, when defined, gate awready, wready, arready with bits of a 16-bit LFSR (seed 16'hACE1, reset to seed) and delay bvalid/rvalid assertion by LFSR-chosen 0-3 cycles, without violating REQ-013.
REQ-024 Without AXI_MEM_BACKPRESSURE_EN, ready/valid timing SHALL be exactly as REQ-009 to REQ-012 with no LFSR logic present.

Verification
REQ-025 Single write addr 0x10, data 0xDEADBEEF, wstrb 0xF, then read 0x10 -> bresp OKAY, rdata 0xDEADBEEF, rlast=1, rvalid one cycle after AR handshake.
REQ-026 INCR write awlen=3 at 0x100 data 1..4, wstrb 0x3 on beat 2 over prior 0xFFFFFFFF -> read-back 1, 0xFFFF0002, 3, 4 with rlast only on beat 4.
REQ-027 Read arlen=7 with rready toggling 1/0 each cycle -> 8 beats, data stable across stalls, rid echoed, no beat lost or duplicated.
REQ-028 Write at BASE_ADDR+4*MEM_WORDS-4 with awlen=1 -> bresp DECERR, last word updated, word 0 unchanged; read same burst -> rresp OKAY then DECERR.
REQ-029 Simultaneous AR and AW/W to 0x20 holding 0x11 writing 0x22 -> read returns 0x11, later read returns 0x22.
REQ-030 rst asserted at beat 3 of arlen=7 read -> rvalid 0 next cycle, arready 1 after release, new read returns stored data.
